// File: rtl/gb_bus_responder.sv
// rtl/gb_bus_responder.sv - SM83 memory responder: map decode, HRAM, IE and OAM DMA engine
module gb_bus_responder #(
  parameter int DMA_LEN         = 160,
  parameter int DMA_START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_r_addr,
  output logic [7:0]  cpu_r_data,
  input  logic [15:0] cpu_w_addr,
  input  logic [7:0]  cpu_w_data,
  input  logic        cpu_w_wen,
  output logic [15:0] ext_r_addr,
  input  logic [7:0]  ext_r_data,
  output logic [15:0] ext_w_addr,
  output logic [7:0]  ext_w_data,
  output logic        ext_wen,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_w_data,
  output logic        oam_wen,
  output logic        dma_active,
  output logic [7:0]  ie
);

  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;

  localparam logic [7:0] LEN_LAST = 8'(DMA_LEN - 1);
  localparam logic [7:0] DLY_LAST = 8'(DMA_START_DELAY - 1);

  dma_state_t state;
  logic [7:0] cnt;
  logic [7:0] dly;
  logic [7:0] src_hi;
  logic [7:0] dma_reg;
  logic [7:0] hram [0:126];

  logic       dma_busy;
  logic       w_hram, w_ie, w_dma, w_oam, w_ext;
  logic       r_hram, r_ie, r_dma, r_ext;
  logic [7:0] rd_next;

  assign dma_busy = (state != IDLE);

  assign w_ie   = (cpu_w_addr == 16'hFFFF);
  assign w_dma  = (cpu_w_addr == 16'hFF46);
  assign w_hram = (cpu_w_addr >= 16'hFF80) && !w_ie;
  assign w_oam  = (cpu_w_addr >= 16'hFE00) && (cpu_w_addr <= 16'hFE9F);
  assign w_ext  = (cpu_w_addr < 16'hFE00) ||
                  ((cpu_w_addr >= 16'hFF00) && (cpu_w_addr < 16'hFF80) && !w_dma);

  assign r_ie   = (cpu_r_addr == 16'hFFFF);
  assign r_dma  = (cpu_r_addr == 16'hFF46);
  assign r_hram = (cpu_r_addr >= 16'hFF80) && !r_ie;
  assign r_ext  = (cpu_r_addr < 16'hFE00) ||
                  ((cpu_r_addr >= 16'hFF00) && (cpu_r_addr < 16'hFF80) && !r_dma);

  // Source is page aligned, so src+k is just the page with k as the low byte.
  assign ext_r_addr = dma_busy ? {src_hi, cnt} : cpu_r_addr;
  assign ext_w_addr = cpu_w_addr;
  assign ext_w_data = cpu_w_data;
  assign ext_wen    = !rst && cpu_w_wen && w_ext && !dma_busy;
  assign dma_active = !rst && dma_busy;

  always_comb begin
    if (state == XFER) begin
      oam_wen    = !rst;
      oam_addr   = cnt;
      oam_w_data = ext_r_data;
    end else begin
      oam_wen    = !rst && cpu_w_wen && w_oam && !dma_busy;
      oam_addr   = cpu_w_addr[7:0];
      oam_w_data = cpu_w_data;
    end
  end

  always_comb begin
    rd_next = 8'hFF;
    if (r_hram)                 rd_next = hram[cpu_r_addr[6:0]];
    else if (r_ie)              rd_next = ie;
    else if (r_dma)             rd_next = dma_reg;
    else if (r_ext && !dma_busy) rd_next = ext_r_data;
  end

  // HRAM deliberately has no reset.
  always_ff @(posedge clk) begin
    if (cpu_w_wen && w_hram) hram[cpu_w_addr[6:0]] <= cpu_w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_r_data <= 8'h00;
      ie         <= 8'h00;
      dma_reg    <= 8'h00;
      src_hi     <= 8'h00;
      state      <= IDLE;
      cnt        <= 8'h00;
      dly        <= 8'h00;
    end else begin
      cpu_r_data <= rd_next;
      if (cpu_w_wen && w_ie) ie <= cpu_w_data;
      if (cpu_w_wen && w_dma) begin
        // Any FF46 write (re)starts the transfer from the new page.
        dma_reg <= cpu_w_data;
        src_hi  <= cpu_w_data;
        cnt     <= 8'h00;
        dly     <= 8'h00;
        state   <= (DMA_START_DELAY == 0) ? XFER : START;
      end else begin
        case (state)
          START: begin
            if (dly == DLY_LAST) begin
              state <= XFER;
              cnt   <= 8'h00;
            end else begin
              dly <= dly + 8'h01;
            end
          end
          XFER: begin
            if (cnt == LEN_LAST) begin
              state <= IDLE;
              cnt   <= 8'h00;
            end else begin
              cnt <= cnt + 8'h01;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_bus_responder.sv
// tb/tb_gb_bus_responder.sv - scoreboard bench for gb_bus_responder
module tb_gb_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_r_addr, cpu_w_addr, ext_r_addr, ext_w_addr;
  logic [7:0]  cpu_r_data, cpu_w_data, ext_r_data, ext_w_data;
  logic        cpu_w_wen, ext_wen, oam_wen, dma_active;
  logic [7:0]  oam_addr, oam_w_data, ie;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [15:0] ext_addr;
    logic        chk_ext;
  } oam_exp_t;

  logic [7:0] rd_q [$];
  oam_exp_t   oam_q [$];
  logic       rd_req = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [7:0] backend(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h65;
  endfunction

  assign ext_r_data = backend(ext_r_addr);

  gb_bus_responder dut (
    .clk(clk), .rst(rst),
    .cpu_r_addr(cpu_r_addr), .cpu_r_data(cpu_r_data),
    .cpu_w_addr(cpu_w_addr), .cpu_w_data(cpu_w_data), .cpu_w_wen(cpu_w_wen),
    .ext_r_addr(ext_r_addr), .ext_r_data(ext_r_data),
    .ext_w_addr(ext_w_addr), .ext_w_data(ext_w_data), .ext_wen(ext_wen),
    .oam_addr(oam_addr), .oam_w_data(oam_w_data), .oam_wen(oam_wen),
    .dma_active(dma_active), .ie(ie)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Read monitor: a read presented before edge N is checked just after edge N.
  always @(posedge clk) begin
    if (rd_req) begin
      logic [7:0] e;
      e = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
      #1;
      check("read_data", {24'h0, cpu_r_data}, {24'h0, e});
    end
  end

  // OAM monitor: every strobe must match the next expected OAM write.
  always @(negedge clk) begin
    if (!rst && oam_wen) begin
      if (oam_q.size() == 0) begin
        check("oam_unexpected", 32'(oam_addr), 32'hFFFF_FFFF);
      end else begin
        oam_exp_t e;
        e = oam_q.pop_front();
        check("oam_addr", 32'(oam_addr), 32'(e.addr));
        check("oam_data", 32'(oam_w_data), 32'(e.data));
        if (e.chk_ext) check("dma_ext_addr", 32'(ext_r_addr), 32'(e.ext_addr));
      end
    end
  end

  task automatic drive(input logic [15:0] ra, input logic rchk, input logic [7:0] rexp,
                       input logic [15:0] wa, input logic [7:0] wd, input logic we);
    cpu_r_addr = ra;
    rd_req     = rchk;
    if (rchk) rd_q.push_back(rexp);
    cpu_w_addr = wa;
    cpu_w_data = wd;
    cpu_w_wen  = we;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    rd_req    = 1'b0;
    cpu_w_wen = 1'b0;
  endtask

  task automatic push_dma(input logic [7:0] page, input int n);
    for (int k = 0; k < n; k++) begin
      oam_exp_t e;
      e.addr     = 8'(k);
      e.ext_addr = {page, 8'(k)};
      e.data     = backend(e.ext_addr);
      e.chk_ext  = 1'b1;
      oam_q.push_back(e);
    end
  endtask

  task automatic count_busy(input string name, input int exp);
    int n = 0;
    while (dma_active && n < 400) begin
      n++;
      tick();
    end
    check(name, 32'(n), 32'(exp));
  endtask

  initial begin
    oam_exp_t e;
    rst = 1'b1;
    cpu_r_addr = 16'h0000;
    cpu_w_addr = 16'hC000;
    cpu_w_data = 8'h12;
    cpu_w_wen  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_r_data", 32'(cpu_r_data), 32'h00);
    check("rst_ie", 32'(ie), 32'h00);
    check("rst_dma_active", 32'(dma_active), 32'h0);
    check("rst_oam_wen", 32'(oam_wen), 32'h0);
    check("rst_ext_wen", 32'(ext_wen), 32'h0);
    rst = 1'b0;
    cpu_w_wen = 1'b0;
    drive(16'hFF46, 1, 8'h00, 16'h0000, 8'h00, 0); tick();

    // HRAM write, readback, and read-before-write on a shared location
    drive(16'h0000, 0, 8'h00, 16'hFF80, 8'h5A, 1); tick();
    drive(16'hFF80, 1, 8'h5A, 16'hFF81, 8'h22, 1); tick();
    drive(16'hFF81, 1, 8'h22, 16'hFF81, 8'h77, 1); tick();
    drive(16'hFF81, 1, 8'h77, 16'h0000, 8'h00, 0); tick();
    drive(16'hFFFE, 0, 8'h00, 16'hFFFE, 8'hE1, 1); tick();
    drive(16'hFFFE, 1, 8'hE1, 16'h0000, 8'h00, 0); tick();

    // IE and external backend
    drive(16'h0000, 0, 8'h00, 16'hFFFF, 8'h1F, 1); tick();
    check("ie_reg", 32'(ie), 32'h1F);
    drive(16'hFFFF, 1, 8'h1F, 16'hC000, 8'hA5, 1);
    check("ext_wen", 32'(ext_wen), 32'h1);
    check("ext_w_addr", 32'(ext_w_addr), 32'hC000);
    check("ext_w_data", 32'(ext_w_data), 32'hA5);
    check("ext_r_addr_idle", 32'(ext_r_addr), 32'hFFFF);
    tick();
    drive(16'hC000, 1, 8'hA5, 16'hFF47, 8'h01, 1);
    check("ext_wen_io", 32'(ext_wen), 32'h1);
    tick();

    // CPU OAM write, unusable region, OAM read
    e.addr = 8'h10; e.data = 8'h33; e.ext_addr = 16'h0; e.chk_ext = 1'b0;
    oam_q.push_back(e);
    drive(16'h0000, 0, 8'h00, 16'hFE10, 8'h33, 1);
    check("oam_cpu_wen", 32'(oam_wen), 32'h1);
    check("oam_cpu_ext_wen", 32'(ext_wen), 32'h0);
    tick();
    drive(16'hFEA0, 1, 8'hFF, 16'hFEA0, 8'h44, 1);
    check("unusable_oam_wen", 32'(oam_wen), 32'h0);
    check("unusable_ext_wen", 32'(ext_wen), 32'h0);
    tick();
    drive(16'hFE10, 1, 8'hFF, 16'h0000, 8'h00, 0); tick();

    // Full DMA from page C1
    push_dma(8'hC1, 160);
    drive(16'h0000, 0, 8'h00, 16'hFF46, 8'hC1, 1);
    check("dma_pre_active", 32'(dma_active), 32'h0);
    tick();
    check("dma_start_oam_wen", 32'(oam_wen), 32'h0);
    count_busy("dma_busy_cycles", 161);
    check("dma_oam_q_empty", 32'(oam_q.size()), 32'h0);
    drive(16'hFF46, 1, 8'hC1, 16'h0000, 8'h00, 0); tick();

    // DMA blocking and restart at k=50
    push_dma(8'hC1, 51);
    push_dma(8'hC2, 160);
    drive(16'h0000, 0, 8'h00, 16'hFF46, 8'hC1, 1); tick();
    tick();
    drive(16'hC000, 1, 8'hFF, 16'hC000, 8'h99, 1);
    check("dma_block_ext_wen", 32'(ext_wen), 32'h0);
    tick();
    drive(16'h0000, 0, 8'h00, 16'hFF90, 8'h99, 1);
    check("dma_block_oam_cpu", 32'(oam_addr), 32'h01);
    tick();
    drive(16'hFF90, 1, 8'h99, 16'hFE20, 8'h55, 1); tick();
    repeat (47) tick();
    drive(16'hFFFF, 1, 8'h1F, 16'hFF46, 8'hC2, 1);
    check("restart_k50", 32'(oam_addr), 32'd50);
    tick();
    check("restart_start_addr", 32'(ext_r_addr), 32'hC200);
    count_busy("restart_busy_cycles", 161);
    check("restart_oam_q_empty", 32'(oam_q.size()), 32'h0);
    drive(16'hFF46, 1, 8'hC2, 16'h0000, 8'h00, 0); tick();

    repeat (3) tick();
    check("read_q_empty", 32'(rd_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_bus_responder.md
Name: gb_bus_responder

Overview:
- Target end of the SM83 core memory interface.
- Accepts the core's independent read port (r_addr/r_data) and write port (w_addr/w_data/w_wen), decodes the Game Boy memory map, and returns registered read data.
- Owns HRAM, the IE register, and the OAM DMA engine (FF46).
- Routes all other traffic to the external backend (cartridge/VRAM/WRAM/IO) and the OAM write port.

Parameters:
- DMA_LEN, 160, bytes per OAM DMA transfer; the counter width is fixed at 8 bits.
- DMA_START_DELAY, 1, idle cycles between the FF46 write and the first transfer cycle.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- cpu_r_addr  in  16  core read address, every cycle
- cpu_r_data  out  8  registered read data
- cpu_w_addr  in  16  core write address
- cpu_w_data  in  8  core write data
- cpu_w_wen  in  1  core write strobe
- ext_r_addr  out  16  backend read address
- ext_r_data  in  8  backend read data, combinational from ext_r_addr
- ext_w_addr  out  16  backend write address
- ext_w_data  out  8  backend write data
- ext_wen  out  1  backend write strobe
- oam_addr  out  8  OAM write index
- oam_w_data  out  8  OAM write data
- oam_wen  out  1  OAM write strobe
- dma_active  out  1  high while the DMA FSM is in START or XFER
- ie  out  8  IE register contents

Behaviour:
- Clocking and reset
  - One clock domain; everything updates on the rising edge of clk.
  - rst forces: cpu_r_data=00, ie=00, FF46 shadow=00, FSM=IDLE, counter=0.
  - HRAM contents are not reset.
  - Combinational outputs under rst: oam_wen=0, ext_wen=0, dma_active=0.
- Address map
  - 0000-FDFF, and FF00-FF7F except FF46: external.
  - FE00-FE9F: OAM, write-only from the CPU; reads return FF.
  - FEA0-FEFF: unusable; reads FF, writes dropped.
  - FF46: DMA source register, read/write.
  - FF80-FFFE: internal 127x8 HRAM.
  - FFFF: IE.
- Read path
  - cpu_r_data is registered: the value for cpu_r_addr sampled at edge N is visible after edge N.
  - One-cycle latency, no stall, a new address every cycle.
  - ext_r_addr = cpu_r_addr when DMA is IDLE.
  - A same-cycle read and write to the same HRAM, IE or FF46 location returns the old value (read-before-write).
- Write path
  - Writes commit at the edge.
  - ext_w_addr and ext_w_data pass cpu_w_addr and cpu_w_data straight through.
  - ext_wen = cpu_w_wen AND external region AND NOT dma_active.
  - OAM write from the CPU (FE00-FE9F, DMA IDLE): oam_wen=1, oam_addr=cpu_w_addr[7:0], oam_w_data=cpu_w_data.
- DMA FSM states: IDLE, START, XFER.
  - IDLE -> START on a write to FF46 with value V.
    - src latched as {V,8'h00}; FF46 shadow = V.
  - START: held for DMA_START_DELAY cycles, then -> XFER with counter=0.
  - XFER, cycle k (k = 0..DMA_LEN-1):
    - ext_r_addr = src+k.
    - oam_addr = k, oam_w_data = ext_r_data, oam_wen = 1.
    - After k = DMA_LEN-1 -> IDLE.
  - A write to FF46 in START or XFER restarts the transfer: -> START with the new src and counter 0. The OAM write in progress that cycle still completes.
- CPU access while dma_active
  - Only HRAM, IE and FF46 are accessible.
  - All other reads return FF.
  - All other writes are dropped: no ext_wen, no CPU-sourced oam_wen.
  - DMA owns ext_r_addr and the OAM port.
- Total busy time: dma_active is high for DMA_START_DELAY + DMA_LEN cycles (161 at defaults).

Test Plan:
- Reset: assert rst 2 cycles -> cpu_r_data=00, ie=00, dma_active=0, oam_wen=0, ext_wen=0; read FF46 -> 00.
- HRAM: write FF80=5A, then read FF80 -> 5A one cycle after the address is presented. Same-cycle write FF81=77 with read FF81 -> old value; the following read -> 77.
- IE/external: write FFFF=1F -> ie=1F next cycle, readback 1F. Write C000=A5 -> ext_wen=1, ext_w_addr=C000, ext_w_data=A5. Read C000 with the backend returning A5 -> cpu_r_data=A5 the next cycle.
- OAM CPU write: write FE10=33 -> oam_wen=1, oam_addr=10, oam_w_data=33. Write FEA0=44 -> no strobes. Read FE10 -> FF.
- DMA: write FF46=C1 -> dma_active=1 next cycle; 1 START cycle; then 160 cycles of oam_addr 00..9F with ext_r_addr C100..C19F and oam_w_data matching the backend; dma_active low after 161 cycles; read FF46 -> C1.
- DMA blocking and restart:
  - During XFER, read C000 -> FF; write C000 -> no ext_wen; HRAM write/read still works.
  - Write FF46=C2 at k=50 -> START, then ext_r_addr restarts at C200 and oam_addr at 00, with a full 160 transfers.
